audio_sample_scheduler: RTL
===========================

# audio_sample_scheduler

Sequences sample playback for the SSM2603 codec path. Up to NUM_VOICES sound-effect voices read from one shared sample memory port, and the scheduler mixes them with saturation. It presents the mixed mono sample on the codec's `audio_output` input, paced by the codec's `sample_req` pulses. Each mix is computed one frame ahead, so the value is already registered when the codec latches it on the cycle after `sample_req[1]`.

## Interface
- `NUM_VOICES`, 4: number of voices; a power of two, 2 to 8.
- `ADDR_W`, 16: sample memory address width, also the width of voice length.
- `clk`  in  1  system clock; the same clock as the codec block.
- `reset`  in  1  synchronous, active-high.
- `sample_req`  in  2  codec request pulses; only bit 1 is used, bit 0 is ignored.
- `audio_output`  out  16  signed mixed sample to the codec.
- `trig_valid`  in  1  voice command valid.
- `trig_ready`  out  1  command accepted when both `trig_valid` and `trig_ready` are high.
- `trig_voice`  in  log2(NUM_VOICES)  target voice.
- `trig_start`  in  ADDR_W  first sample address.
- `trig_len`  in  ADDR_W  number of samples; 0 stops the voice.
- `trig_loop`  in  1  restart at `trig_start` when the end of the samples is reached.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_addr`  out  ADDR_W  read address, valid while `mem_rd` is high.
- `mem_rdata`  in  16  signed sample; valid exactly 2 cycles after `mem_rd`.
- `voice_active`  out  NUM_VOICES  per-voice playing flag.
- `overrun_cnt`  out  8  saturating count of missed mix deadlines.

## Operation
- Per-voice state: `ptr`, `start`, `remain`, `loop`, `active`.
- Registers: `mix_reg` holds the precomputed next sample. `acc` is a signed accumulator, 16+log2(NUM_VOICES) bits wide.
- FSM states are IDLE, ISSUE, WAIT, ACC, SAT. The voice index `v` goes from 0 to NUM_VOICES-1.
- **IDLE:** `trig_ready`=1. When `sample_req[1]` is high:
  - `audio_output` <= `mix_reg`;
  - `acc` <= 0, `v` <= 0;
  - go to ISSUE.
- **ISSUE:**
  - If `active[v]`, pulse `mem_rd` with `mem_addr`=`ptr[v]`, then go to WAIT.
  - If not, skip the voice: step to the next `v`, or go to SAT after the last voice.
- **WAIT:** one cycle, then go to ACC.
- **ACC:**
  - `acc` += sign-extended `mem_rdata`.
  - Advance the voice: `ptr`+1 and `remain`-1.
  - When `remain` was 1: if `loop`, then `ptr`=`start` and `remain`=`len`; otherwise `active`=0.
  - Then step to the next `v`, or go to SAT after the last voice.
- **SAT:**
  - `mix_reg` <= `acc` clamped to the range -32768 to 32767.
  - Go to IDLE.
- Commands are accepted only in IDLE.
  - An accepted command loads `start`, `ptr`=`trig_start` and `remain`=`trig_len`.
  - It sets `active`=(`trig_len`!=0) and loads `loop`.
  - A command to an already active voice restarts that voice.
- **Simultaneous command and `sample_req[1]` in IDLE:** the command is applied, and the mix started in that same cycle uses the new voice state.
- **`sample_req[1]` outside IDLE (overrun):**
  - `audio_output` <= `mix_reg`, which repeats the previous mix.
  - `overrun_cnt` increments and saturates at 255.
  - The mix in progress continues; no restart.
- `voice_active` is `active` registered directly, with no extra delay.
- Address wrap: `ptr` wraps from 2^ADDR_W-1 to 0 modulo 2^ADDR_W.

## Timing
- Reset values: `audio_output`=0, `mix_reg`=0, `mem_rd`=0, `mem_addr`=0, `voice_active`=0, `overrun_cnt`=0, state IDLE.
- `trig_ready` is 0 while `reset` is high.
- `audio_output` changes only on the cycle after a `sample_req[1]` pulse.
- Mix latency from `sample_req[1]` to `mix_reg` loaded:
  - 3 cycles per active voice plus 1 cycle per inactive voice, plus 2 cycles;
  - the maximum is 3·NUM_VOICES+2 (14 for 4 voices), well inside the 256-cycle frame.
- `mem_rd` pulses are always separated by at least 2 cycles; at most one read is outstanding.
- Reset asserted mid-mix aborts the mix, clears all state and discards any `mem_rdata` in flight.

## Test plan
- **Reset:** hold `reset` for 3 cycles, then pulse `sample_req`=2'b10 → `audio_output`=0, `voice_active`=0, no `mem_rd`.
- **Single voice:**
  - Stimulus: trigger voice 0 with start=0x100, len=3, loop=0 (memory holds 100, 200, 300), then four `sample_req[1]` pulses.
  - Required: `audio_output` sequence 0, 100, 200, 300; voice 0 goes inactive after the 3rd mix; `mem_addr` sequence 0x100, 0x101, 0x102.
- **Saturation:** 4 looping voices of len=1 with samples 30000, 30000, -1000, 5000 → `mix_reg`=32767. With all four samples at -20000 → -32768.
- **Loop and restart:**
  - Voice 1 with len=2 and loop=1 reads addresses A, A+1, A, A+1.
  - A retrigger mid-play to B makes the next read address B.
  - A command with len=0 stops the voice: `voice_active[1]`=0 and no further reads.
- **Simultaneous command and `sample_req[1]`** in one IDLE cycle → a `mem_rd` to the new `trig_start` occurs within that mix.
- **Overrun:** two `sample_req[1]` pulses 5 cycles apart with 4 voices active → the second repeats the prior `audio_output`, `overrun_cnt`=1, and the first mix still completes. Also assert reset mid-mix → outputs return to their reset values.

Source files
------------

// File: rtl/audio_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : audio_sample_scheduler
// Function : multi-voice sample sequencer with saturating mono mix for codec
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = 16,
  localparam int C_VOICE_W = $clog2(NUM_VOICES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               sample_req,
  output logic signed [15:0]       audio_output,
  input  logic                     trig_valid,
  output logic                     trig_ready,
  input  logic [C_VOICE_W-1:0]     trig_voice,
  input  logic [ADDR_W-1:0]        trig_start,
  input  logic [ADDR_W-1:0]        trig_len,
  input  logic                     trig_loop,
  output logic                     mem_rd,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [15:0]       mem_rdata,
  output logic [NUM_VOICES-1:0]    voice_active,
  output logic [7:0]               overrun_cnt
);

  localparam int C_ACC_W = 16 + C_VOICE_W;
  localparam logic signed [C_ACC_W-1:0] C_POS_MAX = {{(C_ACC_W-15){1'b0}}, {15{1'b1}}};
  localparam logic signed [C_ACC_W-1:0] C_NEG_MAX = {{(C_ACC_W-15){1'b1}}, 15'd0};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACC   = 3'd3,
    S_SAT   = 3'd4
  } state_t;

  state_t                     r_state;
  logic [C_VOICE_W-1:0]       r_v;
  logic signed [C_ACC_W-1:0]  r_acc;
  logic signed [15:0]         r_mix;
  logic signed [15:0]         r_audio;
  logic [7:0]                 r_overrun;
  logic                       r_mem_rd;
  logic [ADDR_W-1:0]          r_mem_addr;

  logic [ADDR_W-1:0]          r_ptr    [NUM_VOICES];
  logic [ADDR_W-1:0]          r_start  [NUM_VOICES];
  logic [ADDR_W-1:0]          r_len    [NUM_VOICES];
  logic [ADDR_W-1:0]          r_remain [NUM_VOICES];
  logic [NUM_VOICES-1:0]      r_loop;
  logic [NUM_VOICES-1:0]      r_active;

  logic                       w_req;
  logic                       w_cmd;
  logic                       w_last;
  logic [C_VOICE_W-1:0]       w_v_next;
  logic                       w_v0_active;
  logic [ADDR_W-1:0]          w_v0_ptr;
  logic signed [C_ACC_W-1:0]  w_sum;
  logic signed [15:0]         w_sat;
  logic                       w_unused;

  assign w_unused    = sample_req[0];
  assign w_req       = sample_req[1];
  assign trig_ready  = (r_state == S_IDLE) && !reset;
  assign w_cmd       = trig_valid && trig_ready;
  assign w_last      = (r_v == C_VOICE_W'(NUM_VOICES - 1));
  assign w_v_next    = r_v + C_VOICE_W'(1);
  assign w_sum       = r_acc + {{C_VOICE_W{mem_rdata[15]}}, mem_rdata};

  // Voice 0 as it will look next cycle, so the read strobe can be registered
  // on entry to ISSUE even when a command lands in the same IDLE cycle.
  assign w_v0_active = (w_cmd && trig_voice == '0) ? (trig_len != '0) : r_active[0];
  assign w_v0_ptr    = (w_cmd && trig_voice == '0) ? trig_start : r_ptr[0];

  always_comb begin
    w_sat = r_acc[15:0];
    if (r_acc > C_POS_MAX)
      w_sat = 16'sh7FFF;
    else if (r_acc < C_NEG_MAX)
      w_sat = 16'sh8000;
  end

  assign audio_output = r_audio;
  assign mem_rd       = r_mem_rd;
  assign mem_addr     = r_mem_addr;
  assign voice_active = r_active;
  assign overrun_cnt  = r_overrun;

  // Per-voice playback state: written by commands in IDLE, advanced in ACC.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_ptr[i]    <= '0;
        r_start[i]  <= '0;
        r_len[i]    <= '0;
        r_remain[i] <= '0;
      end
      r_loop   <= '0;
      r_active <= '0;
    end else if (w_cmd) begin
      r_ptr[trig_voice]    <= trig_start;
      r_start[trig_voice]  <= trig_start;
      r_len[trig_voice]    <= trig_len;
      r_remain[trig_voice] <= trig_len;
      r_loop[trig_voice]   <= trig_loop;
      r_active[trig_voice] <= (trig_len != '0);
    end else if (r_state == S_ACC) begin
      if (r_remain[r_v] == ADDR_W'(1)) begin
        if (r_loop[r_v]) begin
          r_ptr[r_v]    <= r_start[r_v];
          r_remain[r_v] <= r_len[r_v];
        end else begin
          r_ptr[r_v]    <= r_ptr[r_v] + ADDR_W'(1);
          r_remain[r_v] <= '0;
          r_active[r_v] <= 1'b0;
        end
      end else begin
        r_ptr[r_v]    <= r_ptr[r_v] + ADDR_W'(1);
        r_remain[r_v] <= r_remain[r_v] - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_v        <= '0;
      r_acc      <= '0;
      r_mix      <= '0;
      r_audio    <= '0;
      r_overrun  <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      if (w_req)
        r_audio <= r_mix;
      if (w_req && r_state != S_IDLE && r_overrun != 8'hFF)
        r_overrun <= r_overrun + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_acc   <= '0;
            r_v     <= '0;
            r_state <= S_ISSUE;
            if (w_v0_active) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_v0_ptr;
            end
          end
        end
        S_ISSUE: begin
          if (r_active[r_v]) begin
            r_state <= S_WAIT;
          end else if (w_last) begin
            r_state <= S_SAT;
          end else begin
            r_v <= w_v_next;
            if (r_active[w_v_next]) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_ptr[w_v_next];
            end
          end
        end
        S_WAIT: begin
          r_state <= S_ACC;
        end
        S_ACC: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_state <= S_SAT;
          end else begin
            r_v     <= w_v_next;
            r_state <= S_ISSUE;
            if (r_active[w_v_next]) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= r_ptr[w_v_next];
            end
          end
        end
        S_SAT: begin
          r_mix   <= w_sat;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
